// File: rtl/ula_multiciclo.sv
// Registered multi-cycle ALU: single-cycle logic/shift/compare ops plus
// iterative shift-add multiply and restoring divide into HI/LO.
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops complete here
// RUN   | one multiply/divide step per clock, WIDTH steps total
// FIX   | apply signs, write HI/LO/result, pulse done
module ula_multiciclo #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic [4:0]       OP,
    output logic [WIDTH-1:0] result,
    output logic             Zero_flag,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [4:0] OP_SLLV  = 5'h03;
    localparam logic [4:0] OP_SRLV  = 5'h04;
    localparam logic [4:0] OP_SRAV  = 5'h05;
    localparam logic [4:0] OP_ADD   = 5'h07;
    localparam logic [4:0] OP_SUB   = 5'h08;
    localparam logic [4:0] OP_AND   = 5'h09;
    localparam logic [4:0] OP_OR    = 5'h0A;
    localparam logic [4:0] OP_XOR   = 5'h0B;
    localparam logic [4:0] OP_NOR   = 5'h0C;
    localparam logic [4:0] OP_SLT   = 5'h0D;
    localparam logic [4:0] OP_SLTU  = 5'h0E;
    localparam logic [4:0] OP_MULT  = 5'h10;
    localparam logic [4:0] OP_DIV   = 5'h12;
    localparam logic [4:0] OP_DIVU  = 5'h13;
    localparam logic [4:0] OP_MFHI  = 5'h14;
    localparam logic [4:0] OP_MFLO  = 5'h15;
    localparam logic [4:0] OP_MTHI  = 5'h16;
    localparam logic [4:0] OP_MTLO  = 5'h17;

    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t state, state_nx;

    logic             accept;
    logic             is_multi;
    logic             signed_op;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] alu;
    logic [SHW-1:0]   sh;

    // iteration registers: acc = upper partial product / partial remainder
    logic [WIDTH-1:0] acc, q, m, a_orig;
    logic [SHW-1:0]   cnt;
    logic             is_div, div_zero, neg_q, neg_r;

    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign accept    = start && (state == IDLE);
    assign busy      = (state != IDLE);
    assign is_multi  = (OP[4:2] == 3'b100);
    assign signed_op = (OP == OP_MULT) || (OP == OP_DIV);
    assign a_neg     = signed_op && In1[WIDTH-1];
    assign b_neg     = signed_op && In2[WIDTH-1];
    assign a_mag     = a_neg ? -In1 : In1;
    assign b_mag     = b_neg ? -In2 : In2;
    assign sh        = In1[SHW-1:0];

    // single-cycle operation result
    always_comb begin
        alu = '0;
        case (OP)
            OP_SLLV: alu = In2 << sh;
            OP_SRLV: alu = In2 >> sh;
            OP_SRAV: alu = $signed(In2) >>> sh;
            OP_ADD:  alu = In1 + In2;
            OP_SUB:  alu = In1 - In2;
            OP_AND:  alu = In1 & In2;
            OP_OR:   alu = In1 | In2;
            OP_XOR:  alu = In1 ^ In2;
            OP_NOR:  alu = ~(In1 | In2);
            OP_SLT:  alu = WIDTH'($signed(In1) < $signed(In2));
            OP_SLTU: alu = WIDTH'(In1 < In2);
            OP_MFHI: alu = hi;
            OP_MFLO: alu = lo;
            OP_MTHI: alu = In1;
            OP_MTLO: alu = In1;
            default: alu = '0;
        endcase
    end

    // step arithmetic and final sign fix-up
    always_comb begin
        mul_sum  = {1'b0, acc} + {1'b0, (q[0] ? m : {WIDTH{1'b0}})};
        div_sh   = {acc, q[WIDTH-1]};
        div_diff = div_sh - {1'b0, m};
        prod     = {acc, q};
        prod_s   = neg_q ? -prod : prod;
        fix_hi   = prod_s[2*WIDTH-1:WIDTH];
        fix_lo   = prod_s[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                fix_hi = a_orig;
                fix_lo = '1;
            end else begin
                fix_hi = neg_r ? -acc : acc;
                fix_lo = neg_q ? -q : q;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // FSM next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && is_multi) state_nx = RUN;
            RUN:     if (cnt == LAST) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // datapath, HI/LO, result and done
    always_ff @(posedge clock) begin
        if (reset) begin
            result    <= '0;
            Zero_flag <= 1'b1;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            acc       <= '0;
            q         <= '0;
            m         <= '0;
            a_orig    <= '0;
            cnt       <= '0;
            is_div    <= 1'b0;
            div_zero  <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && is_multi) begin
                        is_div   <= OP[1];
                        div_zero <= (In2 == '0);
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        a_orig   <= In1;
                        acc      <= '0;
                        cnt      <= '0;
                        q        <= OP[1] ? a_mag : b_mag;
                        m        <= OP[1] ? b_mag : a_mag;
                    end else if (accept) begin
                        result    <= alu;
                        Zero_flag <= (alu == '0);
                        done      <= 1'b1;
                        if (OP == OP_MTHI) hi <= In1;
                        if (OP == OP_MTLO) lo <= In1;
                    end
                end
                RUN: begin
                    cnt <= cnt + SHW'(1);
                    if (is_div) begin
                        if (!div_diff[WIDTH]) begin
                            acc <= div_diff[WIDTH-1:0];
                            q   <= {q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= div_sh[WIDTH-1:0];
                            q   <= {q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= mul_sum[WIDTH:1];
                        q   <= {mul_sum[0], q[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    hi        <= fix_hi;
                    lo        <= fix_lo;
                    result    <= fix_lo;
                    Zero_flag <= (fix_lo == '0);
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ula_multiciclo.md
Name: ula_multiciclo

Overview:
- Parametrised, registered successor of the datapath ALU (ula), with the same op semantics plus iterative multiply and divide.
- Multiply and divide results go to internal HI/LO registers, as in MIPS.
- Sits in the execute stage of the multi-cycle datapath; driven by ula_ctrl (extended to 5-bit op codes).
- Start/busy/done handshake lets the control FSM stall on multi-cycle ops.

Parameters:
WIDTH, 32, operand/result width (≥ 4, power of 2)
SHW, $clog2(WIDTH), shift-amount bits taken from In1

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  request; op accepted on an edge where start=1 and busy=0
In1  in  WIDTH  operand 1 (rs); shift amount = In1[SHW-1:0]
In2  in  WIDTH  operand 2 (rt)
OP  in  5  operation code
result  out  WIDTH  registered result
Zero_flag  out  1  registered; 1 when result==0
busy  out  1  multi-cycle op in progress
done  out  1  one-cycle pulse, result/HI/LO valid
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset: on any edge with reset=1:
  - result=0, Zero_flag=1, busy=0, done=0, hi=0, lo=0.
  - Any in-flight mult/div is aborted.
  - Reset has priority over start.
- Inputs In1, In2, OP are sampled only at the accept edge. The block holds internal copies, so inputs may change afterwards.
- Single-cycle op codes:
  - 0x03 sllv: In2 << sh
  - 0x04 srlv: In2 >> sh (logical)
  - 0x05 srav: $signed(In2) >>> sh
  - 0x07 add, 0x08 sub: two's complement, wrap, no overflow trap
  - 0x09 and, 0x0A or, 0x0B xor, 0x0C nor
  - 0x0D slt: signed compare, result 1 or 0
  - 0x0E sltu: unsigned compare, result 1 or 0
  - 0x14 mfhi: result=hi
  - 0x15 mflo: result=lo
  - 0x16 mthi: hi=In1, result=In1
  - 0x17 mtlo: lo=In1, result=In1
  - Any other code (including 0x00-0x02, 0x06): result=0.
  - Timing: result and Zero_flag update at the accept edge; done=1 for the following cycle; busy stays 0.
- Multi-cycle op codes: 0x10 mult, 0x11 multu, 0x12 div, 0x13 divu.
- FSM states IDLE → RUN → FIX → IDLE:
  - Accept edge: IDLE→RUN, busy=1. Operand magnitudes are latched (absolute value for signed ops), plus a sign record and iteration counter=0.
  - RUN: one shift-add (mult) or restoring shift-subtract (div) step per edge. After WIDTH steps (counter==WIDTH-1) → FIX.
  - FIX edge: apply signs, write hi/lo, set result=new lo and Zero_flag=(new lo==0), busy=0, done=1 for one cycle → IDLE.
  - Latency: done is high exactly WIDTH+1 cycles after the accept cycle. busy is high for WIDTH+1 cycles.
- Multiply: {hi,lo} = full 2·WIDTH-bit product.
  - mult is signed; multu is unsigned.
  - Most-negative × most-negative gives the correct positive product.
- Divide: lo=quotient, hi=remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - Divide by zero: lo=all ones, hi=In1 (dividend as given); same FSM latency; no error flag.
  - Signed most-negative / -1: lo=most-negative, hi=0.
- start while busy=1 is ignored, with no effect on the in-flight op.
- start on the FIX edge is also ignored, because busy is still 1 during that cycle. The next op is accepted at the earliest on the edge after done.
- done is never asserted while busy=1. done falls one cycle after it rises unless a new single-cycle op is accepted, in which case it stays high.
- hi and lo change only at the FIX edge, at an mthi/mtlo accept edge, or on reset.

Test Plan:
- Reset then idle: reset=1 for 2 edges → result=0, Zero_flag=1, hi=lo=0, busy=0, done=0.
- Single-cycle ops (WIDTH=32):
  - sub 5-5 → result=0, Zero_flag=1, done 1 cycle later.
  - slt 0xFFFFFFFF,1 → 1.
  - sltu 0xFFFFFFFF,1 → 0.
  - srav In1=4, In2=0x80000000 → 0xF8000000.
- mult In1=-3 (0xFFFFFFFD), In2=7: busy for 33 cycles, done at cycle 33 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. A start pulsed mid-run is ignored.
- Division results:
  - div -7/2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - divu 7/0 → lo=0xFFFFFFFF, hi=7.
  - div 0x80000000/-1 → lo=0x80000000, hi=0.
- Reset mid-operation: reset asserted at cycle 10 of a multu → busy=0, hi=lo=0, no done pulse. The next mflo returns 0.
- Back-to-back and WIDTH=8 instance:
  - mtlo 0x12 then mflo → result=0x12.
  - WIDTH=8: multu 0xFF×0xFF → hi=0xFE, lo=0x01, latency 9 cycles.
